// File: rtl/io_pkg.sv
// Shared types and constants for the I/O port controller: converter FSM states
// and active-low gfedcba segment patterns.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_7seg.sv
// Decodes one BCD digit to active-low gfedcba segments; non-decimal codes
// blank the digit.
module bcd_to_7seg
  import io_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/io_port_controller.sv
// Memory-mapped switch reader and binary-to-7-segment display writer using a
// serial double-dabble converter. Define IO_DEBOUNCE_EN to add switch debouncing.
module io_port_controller
  import io_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SW_W       = 10,
  parameter int N_DIGITS   = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_en,
  input  logic                  io_sel,
  input  logic [SW_W-1:0]       switch_dado,
  input  logic [DATA_W-1:0]     entrada_dado,
  output logic [DATA_W-1:0]     saida_dado,
  output logic [7*N_DIGITS-1:0] hex,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  if (SW_W > DATA_W) begin : g_bad_sw_w
    $error("SW_W must not exceed DATA_W");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  logic [SW_W-1:0] sw_meta_q, sw_sync_q, sw_cond;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= switch_dado;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt_q [SW_W];
  logic [SW_W-1:0]  deb_val_q;

  // A bit that returns to its accepted level restarts its counter, so only an
  // unbroken run of DEB_CYCLES differing samples is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_val_q <= '0;
      for (int b = 0; b < SW_W; b++) deb_cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < SW_W; b++) begin
        if (sw_sync_q[b] == deb_val_q[b]) begin
          deb_cnt_q[b] <= '0;
        end else if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_val_q[b] <= sw_sync_q[b];
          deb_cnt_q[b] <= '0;
        end else begin
          deb_cnt_q[b] <= deb_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  assign sw_cond = deb_val_q;
`else
  assign sw_cond = sw_sync_q;
`endif

  conv_state_e           state_q, state_d;
  logic [DATA_W-1:0]     rd_q, rd_d;
  logic [DATA_W-1:0]     pend_val_q, pend_val_d;
  logic [DATA_W-1:0]     shreg_q, shreg_d;
  logic                  pend_q, pend_d;
  logic                  ovf_work_q, ovf_work_d;
  logic                  ovf_q, ovf_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [7*N_DIGITS-1:0] hex_q, hex_d, seg_w;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dec
    bcd_to_7seg u_dec (
      .digit_i (bcd_q[4*k +: 4]),
      .seg_o   (seg_w[7*k +: 7])
    );
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // A write is applied after the FSM so that a write on the LOAD edge stays
  // pending rather than being cleared with the value just consumed.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    bitcnt_d   = bitcnt_q;
    ovf_work_d = ovf_work_q;
    ovf_d      = ovf_q;
    hex_d      = hex_q;

    case (state_q)
      IDLE: begin
        if (pend_q) state_d = LOAD;
      end
      LOAD: begin
        shreg_d    = pend_val_q;
        pend_d     = 1'b0;
        bcd_d      = '0;
        bitcnt_d   = '0;
        ovf_work_d = 1'b0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        bcd_d    = {bcd_adj[BCD_W-2:0], shreg_q[DATA_W-1]};
        shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bcd_adj[BCD_W-1]) ovf_work_d = 1'b1;
        if (bitcnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        hex_d   = ovf_work_q ? {N_DIGITS{SEG_DASH}} : seg_w;
        ovf_d   = ovf_work_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (io_en && io_sel) rd_d = DATA_W'(sw_cond);
    if (io_en && !io_sel) begin
      pend_d     = 1'b1;
      pend_val_d = entrada_dado;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      shreg_q    <= '0;
      bcd_q      <= '0;
      bitcnt_q   <= '0;
      ovf_work_q <= 1'b0;
      ovf_q      <= 1'b0;
      hex_q      <= {N_DIGITS{SEG_0}};
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      bitcnt_q   <= bitcnt_d;
      ovf_work_q <= ovf_work_d;
      ovf_q      <= ovf_d;
      hex_q      <= hex_d;
    end
  end

  assign saida_dado = rd_q;
  assign hex        = hex_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_io_port_controller.sv
// Self-checking bench for io_port_controller: table vectors, randomized
// conversions against a decimal model, and multi-cycle corner sequences.
module tb_io_port_controller;

  localparam int DATA_W     = 32;
  localparam int SW_W       = 10;
  localparam int N_DIGITS   = 8;
  localparam int DEB_CYCLES = 16;
  localparam int HEX_W      = 7 * N_DIGITS;
`ifdef IO_DEBOUNCE_EN
  localparam int SETTLE = DEB_CYCLES + 3;
`else
  localparam int SETTLE = 3;
`endif
  localparam logic [6:0] DASH = 7'h3F;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  io_en = 1'b0;
  logic                  io_sel = 1'b0;
  logic [SW_W-1:0]       switch_dado = '0;
  logic [DATA_W-1:0]     entrada_dado = '0;
  logic [DATA_W-1:0]     saida_dado;
  logic [HEX_W-1:0]      hex;
  logic                  busy;
  logic                  overflow;

  int assertCount = 0;
  int failCount   = 0;

  logic [HEX_W-1:0] curHex;
  logic             curOvf;

  logic [6:0] segTable [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [31:0] value;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  io_port_controller #(
    .DATA_W     (DATA_W),
    .SW_W       (SW_W),
    .N_DIGITS   (N_DIGITS),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_en        (io_en),
    .io_sel       (io_sel),
    .switch_dado  (switch_dado),
    .entrada_dado (entrada_dado),
    .saida_dado   (saida_dado),
    .hex          (hex),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [HEX_W-1:0] hexFromBcd(input logic [31:0] bcd, input logic ovf);
    logic [HEX_W-1:0] h;
    h = '0;
    for (int k = 0; k < N_DIGITS; k++) h[7*k +: 7] = ovf ? DASH : segTable[bcd[4*k +: 4]];
    return h;
  endfunction

  function automatic longint unsigned maxDisplay();
    longint unsigned m;
    m = 1;
    for (int k = 0; k < N_DIGITS; k++) m = m * 10;
    return m - 1;
  endfunction

  function automatic logic modelOvf(input longint unsigned v);
    return v > maxDisplay();
  endfunction

  function automatic logic [HEX_W-1:0] modelHex(input longint unsigned v);
    logic [HEX_W-1:0] h;
    longint unsigned  r;
    h = '0;
    r = v;
    for (int k = 0; k < N_DIGITS; k++) begin
      h[7*k +: 7] = modelOvf(v) ? DASH : segTable[int'(r % 10)];
      r = r / 10;
    end
    return h;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic en, input logic sel, input logic [DATA_W-1:0] data);
    @(negedge clock);
    io_en        = en;
    io_sel       = sel;
    entrada_dado = data;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic convertAndCheck(input logic [31:0] val, input logic [HEX_W-1:0] expHex,
                                 input logic expOvf, input string tag);
    int               busyCnt;
    logic [HEX_W-1:0] hexPre;
    logic             ovfPre;
    busyCnt = 0;
    hexPre  = '0;
    ovfPre  = 1'b0;
    applyStimulus(1'b1, 1'b0, val);
    for (int e = 1; e <= DATA_W + 3; e++) begin
      applyStimulus(1'b0, 1'b0, '0);
      busyCnt += int'(busy);
      if (e == DATA_W + 2) begin
        hexPre = hex;
        ovfPre = overflow;
      end
    end
    checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'(DATA_W + 2));
    checkOutput({tag, " hex before done"}, 64'(hexPre), 64'(curHex));
    checkOutput({tag, " ovf before done"}, 64'(ovfPre), 64'(curOvf));
    checkOutput({tag, " hex"}, 64'(hex), 64'(expHex));
    checkOutput({tag, " overflow"}, 64'(overflow), 64'(expOvf));
    checkOutput({tag, " busy after"}, 64'(busy), 64'd0);
    curHex = expHex;
    curOvf = expOvf;
  endtask

  initial begin
    logic [HEX_W-1:0] zeros;
    logic [HEX_W-1:0] hexA, hexB;
    logic             seen7;
    logic [31:0]      v;
    logic [SW_W-1:0]  sw;

    vecs[0] = '{32'd12345678,  32'h12345678, 1'b0};
    vecs[1] = '{32'd0,         32'h00000000, 1'b0};
    vecs[2] = '{32'd99999999,  32'h99999999, 1'b0};
    vecs[3] = '{32'd100000000, 32'h00000000, 1'b1};
    vecs[4] = '{32'hFFFFFFFF,  32'h00000000, 1'b1};
    vecs[5] = '{32'd5,         32'h00000005, 1'b0};
    vecs[6] = '{32'd1000,      32'h00001000, 1'b0};
    vecs[7] = '{32'd90817263,  32'h90817263, 1'b0};

    zeros  = hexFromBcd(32'h0, 1'b0);
    curHex = zeros;
    curOvf = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset saida_dado", 64'(saida_dado), 64'd0);
    checkOutput("reset hex", 64'(hex), 64'(zeros));
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      convertAndCheck(vecs[i].value, hexFromBcd(vecs[i].bcd, vecs[i].ovf), vecs[i].ovf,
                      $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      v = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom % 100000000);
      convertAndCheck(v, modelHex(longint'(v)), modelOvf(longint'(v)), $sformatf("rand%0d", i));
    end

    // Last-write-wins: 7 and 9 arrive while 5 is converting.
    seen7 = 1'b0;
    hexA  = '0;
    hexB  = '0;
    applyStimulus(1'b1, 1'b0, 32'd5);
    for (int e = 1; e <= 2 * DATA_W + 8; e++) begin
      if (e == 5)       applyStimulus(1'b1, 1'b0, 32'd7);
      else if (e == 10) applyStimulus(1'b1, 1'b0, 32'd9);
      else              applyStimulus(1'b0, 1'b0, '0);
      if (hex === modelHex(7)) seen7 = 1'b1;
      if (e == DATA_W + 3) hexA = hex;
      if (e == 2 * DATA_W + 6) hexB = hex;
    end
    checkOutput("lww first value", 64'(hexA), 64'(modelHex(5)));
    checkOutput("lww second value", 64'(hexB), 64'(modelHex(9)));
    checkOutput("lww 7 never shown", 64'(seen7), 64'd0);
    curHex = modelHex(9);

    // Write landing on the DONE edge is converted in the next pass.
    applyStimulus(1'b1, 1'b0, 32'd1234);
    idle(DATA_W + 2);
    applyStimulus(1'b1, 1'b0, 32'd4321);
    checkOutput("done-edge first value", 64'(hex), 64'(modelHex(1234)));
    checkOutput("done-edge busy idle gap", 64'(busy), 64'd0);
    idle(DATA_W + 2);
    checkOutput("done-edge hold", 64'(hex), 64'(modelHex(1234)));
    idle(1);
    checkOutput("done-edge second value", 64'(hex), 64'(modelHex(4321)));
    curHex = modelHex(4321);

    // Switch reads and saida_dado hold.
    switch_dado = 10'h2A5;
    idle(SETTLE);
    applyStimulus(1'b1, 1'b1, '0);
    checkOutput("read 2A5", 64'(saida_dado), 64'h2A5);
    switch_dado = 10'h155;
    idle(SETTLE);
    applyStimulus(1'b1, 1'b0, 32'd42);
    checkOutput("saida holds", 64'(saida_dado), 64'h2A5);
    idle(DATA_W + 3);
    checkOutput("write does not touch read data", 64'(saida_dado), 64'h2A5);
    curHex = modelHex(42);
    applyStimulus(1'b1, 1'b1, '0);
    checkOutput("read 155", 64'(saida_dado), 64'h155);
    for (int i = 0; i < 4; i++) begin
      sw = SW_W'($urandom);
      switch_dado = sw;
      idle(SETTLE);
      applyStimulus(1'b1, 1'b1, '0);
      checkOutput($sformatf("read rand%0d", i), 64'(saida_dado), 64'(sw));
    end

`ifdef IO_DEBOUNCE_EN
    switch_dado = 10'h155;
    idle(SETTLE);
    for (int i = 0; i < 10; i++) begin
      switch_dado[0] = ~switch_dado[0];
      idle(DEB_CYCLES / 4);
    end
    switch_dado[0] = 1'b0;
    applyStimulus(1'b1, 1'b1, '0);
    checkOutput("debounce bounce rejected", 64'(saida_dado), 64'h155);
    idle(DEB_CYCLES + 2);
    applyStimulus(1'b1, 1'b1, '0);
    checkOutput("debounce stable accepted", 64'(saida_dado), 64'h154);
`endif

    // Reset in the middle of a SHIFT pass aborts it with nothing displayed.
    applyStimulus(1'b1, 1'b0, 32'd999);
    idle(11);
    checkOutput("abort busy before reset", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort hex", 64'(hex), 64'(zeros));
    checkOutput("abort saida", 64'(saida_dado), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(DATA_W + 6);
    checkOutput("abort no late result", 64'(hex), 64'(zeros));
    checkOutput("abort stays idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/io_port_controller.md
IO_PORT_CONTROLLER -- requirements
Module: io_port_controller

Interface
REQ-001 Parameter DATA_W, default 32: width of the CPU data bus and of the display value.
REQ-002 Parameter SW_W, default 10: number of switch inputs, SW_W <= DATA_W.
REQ-003 Parameter N_DIGITS, default 8: number of decimal digits and 7-segment outputs.
REQ-004 Parameter DEB_CYCLES, default 16: debounce stability window in clocks.
REQ-005 Port: clock  in  1  single clock; all state updates on the rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-high reset.
REQ-007 Port: io_en  in  1  I/O access strobe, one cycle per access.
REQ-008 Port: io_sel  in  1  qualifies io_en; 1 = read switches, 0 = write display.
REQ-009 Port: switch_dado  in  SW_W  raw asynchronous switch levels.
REQ-010 Port: entrada_dado  in  DATA_W  value to display, unsigned.
REQ-011 Port: saida_dado  out  DATA_W  registered switch read data.
REQ-012 Port: hex  out  7*N_DIGITS  segments; digit k occupies bits 7k+6..7k, encoded active-low gfedcba.
REQ-013 Port: busy  out  1  high while a conversion is in progress.
REQ-014 Port: overflow  out  1  displayed value exceeds 10^N_DIGITS-1.

Function
REQ-015 The switches SHALL pass through a 2-flop synchronizer before any use.
REQ-016 A read (io_en=1, io_sel=1) SHALL load saida_dado with the conditioned switches, zero-extended, on that edge; saida_dado SHALL otherwise hold.
REQ-017 A write (io_en=1, io_sel=0) SHALL capture entrada_dado into a pending register on that edge and set a pending flag.
REQ-018 The converter FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-019 IDLE -> LOAD when the pending flag is set; LOAD copies the pending value into the shift register, clears pending and zeroes the BCD accumulator.
REQ-020 SHIFT SHALL perform one double-dabble step per clock (add 3 to each digit >= 5, then shift left 1) for exactly DATA_W clocks, then -> DONE.
REQ-021 DONE SHALL commit the decoded digits to hex and the overflow flag to overflow in one edge, then -> IDLE.
REQ-022 Latency: hex and overflow SHALL update exactly DATA_W+3 edges after the write edge when the FSM was IDLE.
REQ-023 busy SHALL be high in LOAD, SHIFT and DONE and low in IDLE.
REQ-024 A write during busy SHALL overwrite the pending value without disturbing the running conversion; only the last value SHALL be converted next (one-deep, last-write-wins).
REQ-025 A write on the DONE edge SHALL be converted in the following pass.
REQ-026 Overflow SHALL be set when any 1 is shifted out of the top BCD digit during SHIFT; if set, every digit SHALL show a dash (segment g only).
REQ-027 hex and overflow SHALL hold their committed values between DONE states.
REQ-028 Simultaneous read and write is impossible by encoding; io_en=0 SHALL cause no state change except synchronizer/debounce updates.

Reset
REQ-029 Reset SHALL force: saida_dado=0, hex=all digits showing "0", overflow=0, busy=0, FSM=IDLE, pending cleared, synchronizer and debounce state 0.
REQ-030 Reset asserted mid-conversion SHALL abort it; no partial result SHALL reach hex.

Configuration
REQ-031 With IO_DEBOUNCE_EN defined, each synchronized switch bit SHALL update its conditioned value only after DEB_CYCLES consecutive equal samples; a per-bit counter SHALL restart on any change.
REQ-032 Without IO_DEBOUNCE_EN, the conditioned value SHALL equal the synchronizer output, and no counters SHALL exist.

Structure
REQ-033 Package io_pkg SHALL hold the FSM state enum, the 7-segment digit constants 0-9 and the dash constant.
REQ-034 Sub-module bcd_to_7seg SHALL map one 4-bit digit to 7 active-low segments, instantiated N_DIGITS times.

Verification
REQ-035 Reset, then write 12345678 -> busy high for DATA_W+2 clocks; hex shows 1,2,3,4,5,6,7,8 (digit 7..0) at edge DATA_W+3; overflow=0.
REQ-036 Write 100000000 with N_DIGITS=8 -> overflow=1 and all digits show a dash.
REQ-037 Write 5, then write 7 and write 9 while busy -> display shows 5, then 9; 7 is never displayed.
REQ-038 Set switches to 10'h2A5, wait 3 clocks (DEB_CYCLES+3 with IO_DEBOUNCE_EN), then read -> saida_dado=32'h000002A5 on the next edge.
REQ-039 With IO_DEBOUNCE_EN, toggle switch 0 at a period shorter than DEB_CYCLES -> read returns the old value; hold it stable DEB_CYCLES -> read returns the new value.
REQ-040 Assert reset at SHIFT cycle 10 of a conversion of 999 -> hex stays at all zeros and busy=0 immediately.
